sample_scan_ctrl: RTL
=====================

// Module: sample_scan_ctrl
// PURPOSE
//   Sequencer feeding the sample test stage. Accepts one triangle plus its bounding box,
//   then walks every sample position in the box in raster order (x fastest), one per cycle.
//   Each cycle it drives triangle, colour and sample location with a sample-valid flag.
//   Downstream backpressure stalls the walk. It accepts the next triangle once the box is done.
// PARAMETERS
//   SIGFIG  24  bits in colour and position
//   RADIX   10  fraction bits in position (1 pixel = 1<<RADIX)
//   VERTS   3   vertices per triangle
//   AXIS    3   axes per vertex (x,y,z)
//   COLORS  3   colour channels
// PORTS
//   clk             in   1                    clock
//   rst             in   1                    reset, asynchronous, active-low
//   tri_R13S        in   SIGFIG[VERTS][AXIS]  triangle (signed)
//   color_R13U      in   SIGFIG[COLORS]       triangle colour
//   box_R13S        in   SIGFIG[2][2]         [0]=lower-left (x,y), [1]=upper-right (x,y); signed
//   validTri_R13H   in   1                    upstream triangle valid
//   halt_R13L       out  1                    1 = ready to accept a triangle
//   subSample_RnnnnU in  4                    one-hot MSAA step: 1000=1px,0100=1/2,0010=1/4,0001=1/8
//   halt_RnnnnL     in   1                    downstream ready; 0 stalls the walk
//   tri_R14S        out  SIGFIG[VERTS][AXIS]  captured triangle
//   color_R14U      out  SIGFIG[COLORS]       captured colour
//   sample_R14S     out  SIGFIG[2]            current sample (x,y)
//   validSamp_R14H  out  1                    sample_R14S is a valid test location
// BEHAVIOUR
//   - Reset (rst=0, async): state=WAIT; all outputs 0 except halt_R13L=1.
//   - Step: step = 1<<(RADIX-k). k=0,1,2,3 for subSample 1000,0100,0010,0001.
//     Any non-one-hot value uses k=0. The step is sampled at accept and held for the whole triangle.
//   - FSM WAIT: halt_R13L=1, validSamp_R14H=0.
//     Transfer when validTri_R13H && halt_R13L. Capture tri, colour, box and step.
//     Set sample_R14S=box ll. Go to TEST. The first sample is valid on the next cycle (latency 1).
//   - FSM TEST: halt_R13L=0, validSamp_R14H=1. A sample is consumed on any cycle with halt_RnnnnL=1.
//     When consumed:
//       x_nxt=x+step.
//       If x_nxt<=ur_x then x=x_nxt.
//       Else x=ll_x and y_nxt=y+step. If y_nxt>ur_y the walk is done: go to WAIT with validSamp_R14H=0.
//   - halt_RnnnnL=0 in TEST: all outputs hold their values, validSamp_R14H stays 1, no advance.
//   - halt_RnnnnL is ignored in WAIT.
//   - Comparisons are signed, SIGFIG wide. Adders are SIGFIG+1 wide internally so x+step cannot
//     wrap past ur. The box is assumed already snapped to the step grid; no re-alignment is done.
//   - Degenerate box (ll==ur): exactly one sample, then WAIT.
//   - Inverted box (ur<ll on either axis): one sample at ll, then WAIT. No hang.
//   - One bubble between triangles. halt_R13L rises the cycle after the last sample is consumed,
//     so a new transfer cannot overlap the final sample.
//   - Reset mid-TEST: the walk aborts at once. Outputs clear, state=WAIT, the captured triangle is discarded.
// CONFIGURATION
//   SAMPLE_COUNT_EN defined: adds output samp_count_R14U [31:0].
//     It counts consumed samples (validSamp_R14H && halt_RnnnnL), saturates at 32'hFFFF_FFFF,
//     and is cleared only by rst.
//   SAMPLE_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
//   1. RADIX=10, subSample=1000, ll=(0,0), ur=(2048,1024), halt_RnnnnL=1 ->
//      valid samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles,
//      then validSamp=0 and halt_R13L=1 the following cycle.
//   2. subSample=0100, ll=(512,512), ur=(1024,1024) ->
//      samples (512,512),(1024,512),(512,1024),(1024,1024); 4 valids.
//   3. Scenario 1 with halt_RnnnnL=0 for 3 cycles on sample (1024,0) ->
//      (1024,0) held for 4 cycles, the sequence resumes unchanged, total 6 consumed samples.
//   4. ll=ur=(3072,-1024) -> exactly one valid sample (3072,-1024). Then the inverted box
//      ll=(1024,0), ur=(0,0) -> one sample (1024,0), back to WAIT.
//   5. Assert rst=0 on the 3rd sample of scenario 1 ->
//      validSamp_R14H=0 and halt_R13L=1 immediately (async). After release, a new triangle starts at its own ll.
//   6. SAMPLE_COUNT_EN: run scenario 1 then scenario 2 -> samp_count_R14U=10. Preload near
//      saturation via force -> the count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/sample_scan_ctrl.sv
// Sample scan sequencer: captures one triangle and its bounding box, then walks every sample
// location in raster order (x fastest), one per cycle, stalling on downstream backpressure.
// Optional build macro SAMPLE_COUNT_EN adds a saturating consumed-sample counter output.
module sample_scan_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]           color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]             box_R13S,
  input  logic                                    validTri_R13H,
  output logic                                    halt_R13L,
  input  logic [3:0]                              subSample_RnnnnU,
  input  logic                                    halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  output logic [1:0][SIGFIG-1:0]                  sample_R14S,
  output logic                                    validSamp_R14H
`ifdef SAMPLE_COUNT_EN
  ,
  output logic [31:0]                             samp_count_R14U
`endif
);

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
  logic signed [SIGFIG-1:0] samp_x, samp_y;
  logic        [SIGFIG-1:0] step;

  logic signed [SIGFIG:0]   x_nxt, y_nxt;
  logic                     x_fits, y_fits, inverted;
  logic                     accept, consume, walk_done;

  // Non-one-hot encodings fall back to a whole-pixel step.
  function automatic logic [SIGFIG-1:0] step_of(input logic [3:0] sub);
    logic [SIGFIG-1:0] unit;
    unit = {{(SIGFIG-1){1'b0}}, 1'b1};
    case (sub)
      4'b0100: return unit << (RADIX - 1);
      4'b0010: return unit << (RADIX - 2);
      4'b0001: return unit << (RADIX - 3);
      default: return unit << RADIX;
    endcase
  endfunction

`ifdef SAMPLE_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  // One extra bit on the adders keeps x+step from wrapping back below ur.
  assign x_nxt  = $signed({samp_x[SIGFIG-1], samp_x}) + $signed({1'b0, step});
  assign y_nxt  = $signed({samp_y[SIGFIG-1], samp_y}) + $signed({1'b0, step});
  assign x_fits = (x_nxt <= $signed({ur_x[SIGFIG-1], ur_x}));
  assign y_fits = (y_nxt <= $signed({ur_y[SIGFIG-1], ur_y}));
  assign inverted = (ur_x < ll_x) || (ur_y < ll_y);

  assign accept    = validTri_R13H && halt_R13L;
  assign consume   = (state == TEST) && halt_RnnnnL;
  assign walk_done = consume && (inverted || (!x_fits && !y_fits));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    halt_R13L      = 1'b0;
    validSamp_R14H = 1'b0;
    case (state)
      WAIT: begin
        halt_R13L = 1'b1;
        if (accept) state_nxt = TEST;
      end
      TEST: begin
        validSamp_R14H = 1'b1;
        if (walk_done) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Capture stage: triangle, colour, box and step are latched on transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_R14S   <= '0;
      color_R14U <= '0;
      ll_x       <= '0;
      ll_y       <= '0;
      ur_x       <= '0;
      ur_y       <= '0;
      step       <= '0;
    end else if (accept) begin
      tri_R14S   <= tri_R13S;
      color_R14U <= color_R13U;
      ll_x       <= $signed(box_R13S[0][0]);
      ll_y       <= $signed(box_R13S[0][1]);
      ur_x       <= $signed(box_R13S[1][0]);
      ur_y       <= $signed(box_R13S[1][1]);
      step       <= step_of(subSample_RnnnnU);
    end
  end

  // Walk stage: the sample position advances only when downstream consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_x <= '0;
      samp_y <= '0;
    end else if (accept) begin
      samp_x <= $signed(box_R13S[0][0]);
      samp_y <= $signed(box_R13S[0][1]);
    end else if (consume && !walk_done) begin
      if (x_fits) begin
        samp_x <= x_nxt[SIGFIG-1:0];
      end else begin
        samp_x <= ll_x;
        samp_y <= y_nxt[SIGFIG-1:0];
      end
    end
  end

  assign sample_R14S[0] = samp_x;
  assign sample_R14S[1] = samp_y;

`ifdef SAMPLE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         samp_count_R14U <= '0;
    else if (consume) samp_count_R14U <= sat_inc(samp_count_R14U);
  end
`endif

endmodule
